// File: rtl/Types.sv
// Shared types for the data-bus responder.
// Contents: dbus_size_t (RISC-V f3 access size), resp_state_t (responder FSM
// state) and size_illegal(), which flags undefined sizes and unsigned stores.
package Types;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    BYTE   = 3'd0,
    HALF   = 3'd1,
    WORD   = 3'd2,
    BYTE_U = 3'd4,
    HALF_U = 3'd5
  } dbus_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } resp_state_t;

  // Sizes 3/6/7 are undefined; unsigned variants only make sense for loads.
  function automatic logic size_illegal(input logic [2:0] size, input logic is_write);
    case (size)
      BYTE, HALF, WORD: size_illegal = 1'b0;
      BYTE_U, HALF_U:   size_illegal = is_write;
      default:          size_illegal = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dbus_responder_if.sv
// Data-bus handshake between the core control unit (master) and the
// responder (slave).
// Signals: dbus_re/dbus_we request, addr byte address, size f3 access size,
// wdata right-aligned store data, cycle_end write-back strobe; rdata load
// data, stall (combinational freeze), fault (illegal transaction, in DONE).
interface dbus_responder_if;
  logic        dbus_re;
  logic        dbus_we;
  logic [31:0] addr;
  logic [2:0]  size;
  logic [31:0] wdata;
  logic        cycle_end;
  logic [31:0] rdata;
  logic        stall;
  logic        fault;

  modport master (
    output dbus_re, dbus_we, addr, size, wdata, cycle_end,
    input  rdata, stall, fault
  );

  modport slave (
    input  dbus_re, dbus_we, addr, size, wdata, cycle_end,
    output rdata, stall, fault
  );
endinterface

// File: rtl/dbus_lane_align.sv
// Combinational byte-lane steering for the responder.
// Ports: size_i/off_i select the access; wdata_i is right-aligned store data;
// word_i is the current array word; st_word_o is word_i with the selected
// lanes replaced; ld_data_o is the extracted, extended load value.
module dbus_lane_align
  import Types::*;
(
  input  logic [2:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] word_i,
  output logic [31:0] st_word_o,
  output logic [31:0] ld_data_o
);

  logic [4:0]  shamt;
  logic [3:0]  be_base;
  logic [3:0]  be;
  logic [31:0] mask;
  logic [31:0] wsh;
  logic [31:0] rsh;

  assign shamt = {off_i, 3'b000};

  // Store merge: lanes above bit 3 fall off; misaligned sizes are faulted upstream.
  always_comb begin
    be_base = 4'b0000;
    case (size_i)
      BYTE, BYTE_U: be_base = 4'b0001;
      HALF, HALF_U: be_base = 4'b0011;
      WORD:         be_base = 4'b1111;
      default:      be_base = 4'b0000;
    endcase
    be        = be_base << off_i;
    mask      = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    wsh       = wdata_i << shamt;
    st_word_o = (word_i & ~mask) | (wsh & mask);
  end

  // Load extract: shift the addressed lane down, then extend.
  always_comb begin
    rsh = word_i >> shamt;
    case (size_i)
      BYTE:    ld_data_o = {{24{rsh[7]}}, rsh[7:0]};
      HALF:    ld_data_o = {{16{rsh[15]}}, rsh[15:0]};
      BYTE_U:  ld_data_o = {24'h000000, rsh[7:0]};
      HALF_U:  ld_data_o = {16'h0000, rsh[15:0]};
      default: ld_data_o = rsh;
    endcase
  end

endmodule

// File: rtl/dbus_responder.sv
// Data-bus responder: a word array behind a stall-based request handshake.
// Ports: clk, rst (async, active-high), bus (slave modport of
// dbus_responder_if). A request is taken in IDLE, stalls WAIT_CYCLES+1
// cycles, then completes in DONE with registered rdata/fault until the core
// closes the cycle with cycle_end or drops its request.
module dbus_responder
  import Types::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic             clk,
  input logic             rst,
  dbus_responder_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = 4;

  resp_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [2:0]    size_q, size_d;
  logic          re_q, re_d;
  logic          we_q, we_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          fault_q, fault_d;

  logic [31:0]   mem_q [DEPTH_WORDS];

  logic          req_c;
  logic          stall_c;
  logic          finish_c;
  logic          eff_re_c, eff_we_c;
  logic [31:0]   eff_addr_c, eff_wdata_c;
  logic [2:0]    eff_size_c;
  logic          illegal_c;
  logic          mem_we_c;
  logic [31:0]   rd_word_c, st_word_c, ld_data_c;

  assign req_c = bus.dbus_re | bus.dbus_we;

  // Completion can happen straight from IDLE when WAIT_CYCLES is 0, so the
  // request seen at completion is either the live bus or the latched copy.
  always_comb begin
    if (state_q == IDLE) begin
      eff_re_c    = bus.dbus_re;
      eff_we_c    = bus.dbus_we;
      eff_addr_c  = bus.addr;
      eff_size_c  = bus.size;
      eff_wdata_c = bus.wdata;
    end else begin
      eff_re_c    = re_q;
      eff_we_c    = we_q;
      eff_addr_c  = addr_q;
      eff_size_c  = size_q;
      eff_wdata_c = wdata_q;
    end
  end

  // Legality of the transaction being completed.
  always_comb begin
    illegal_c = 1'b0;
    if (eff_re_c && eff_we_c) illegal_c = 1'b1;
    if (size_illegal(eff_size_c, eff_we_c)) illegal_c = 1'b1;
    if ((eff_size_c == HALF || eff_size_c == HALF_U) && eff_addr_c[0]) illegal_c = 1'b1;
    if (eff_size_c == WORD && eff_addr_c[1:0] != 2'b00) illegal_c = 1'b1;
    if (eff_addr_c[31:2] >= 30'(DEPTH_WORDS)) illegal_c = 1'b1;
  end

  assign rd_word_c = mem_q[eff_addr_c[AW+1:2]];

  dbus_lane_align u_align (
    .size_i    (eff_size_c),
    .off_i     (eff_addr_c[1:0]),
    .wdata_i   (eff_wdata_c),
    .word_i    (rd_word_c),
    .st_word_o (st_word_c),
    .ld_data_o (ld_data_c)
  );

  // Next-state and outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    size_d   = size_q;
    re_d     = re_q;
    we_d     = we_q;
    rdata_d  = rdata_q;
    fault_d  = fault_q;
    stall_c  = 1'b0;
    finish_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_c) begin
          stall_c = 1'b1;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          size_d  = bus.size;
          re_d    = bus.dbus_re;
          we_d    = bus.dbus_we;
          cnt_d   = '0;
          if (WAIT_CYCLES == 0) begin
            state_d  = DONE;
            finish_c = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        if (cnt_q == CW'(WAIT_CYCLES - 1)) begin
          state_d  = DONE;
          finish_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (bus.cycle_end || !req_c) begin
          state_d = IDLE;
          fault_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (finish_c) begin
      fault_d = illegal_c;
      rdata_d = illegal_c ? 32'h0 : ld_data_c;
    end
  end

  assign mem_we_c = finish_c & eff_we_c & ~illegal_c;

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      re_q    <= re_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  // Data array keeps its contents across reset; a commit coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (mem_we_c && !rst) mem_q[eff_addr_c[AW+1:2]] <= st_word_c;
  end

  assign bus.stall = stall_c & ~rst;
  assign bus.rdata = rdata_q;
  assign bus.fault = fault_q;

endmodule

// File: tb/tb_dbus_responder.sv
// Self-checking bench for dbus_responder (DEPTH_WORDS=64, WAIT_CYCLES=2).
module tb_dbus_responder;
  import Types::*;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned WAITC = 2;

  typedef struct {
    bit          re;
    bit          we;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_fault;
    bit          chk_rdata;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    bit          fault;
    bit          chk_rdata;
  } exp_t;

  logic clk;
  logic rst;
  dbus_responder_if bus ();

  dbus_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs[$];
  exp_t sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input bit re, input bit we, input logic [31:0] addr, input logic [2:0] size,
                     input logic [31:0] wdata, input logic [31:0] exp_rdata, input bit exp_fault,
                     input bit chk_rdata);
    vec_t v;
    v.re = re; v.we = we; v.addr = addr; v.size = size; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_fault = exp_fault; v.chk_rdata = chk_rdata;
    vecs.push_back(v);
  endtask

  // Count stalled cycles from the current point, then compare the DONE outputs
  // against the oldest scoreboard entry.
  task automatic finish_txn(input string name);
    int   stalls;
    bit   early_fault;
    exp_t e;
    stalls = 0;
    early_fault = 1'b0;
    #1;
    while (bus.stall && stalls < 40) begin
      stalls++;
      if (bus.fault) early_fault = 1'b1;
      @(negedge clk);
      #1;
    end
    chk({name, "_stalls"}, 32'(stalls), 32'(WAITC + 1));
    chk({name, "_fault_busy"}, 32'(early_fault), 32'h0);
    if (sb_q.size() == 0) begin
      chk({name, "_sb_empty"}, 32'h1, 32'h0);
    end else begin
      e = sb_q.pop_front();
      chk({name, "_fault"}, 32'(bus.fault), 32'(e.fault));
      if (e.chk_rdata) chk({name, "_rdata"}, bus.rdata, e.rdata);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.dbus_re = v.re;
    bus.dbus_we = v.we;
    bus.addr    = v.addr;
    bus.size    = v.size;
    bus.wdata   = v.wdata;
  endtask

  task automatic run_vec(input vec_t v, input bit use_ce, input string name);
    exp_t e;
    e.rdata = v.exp_rdata; e.fault = v.exp_fault; e.chk_rdata = v.chk_rdata;
    sb_q.push_back(e);
    drive(v);
    finish_txn(name);
    bus.cycle_end = use_ce;
    bus.dbus_re   = 1'b0;
    bus.dbus_we   = 1'b0;
    @(negedge clk);
    bus.cycle_end = 1'b0;
    #1;
    chk({name, "_fault_exit"}, 32'(bus.fault), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bit   bad;
    exp_t e;
    vec_t v;

    // Table: store/load/extension, partial stores, faults, boundaries.
    add(0, 1, 32'h10, WORD,   32'hDEADBEEF, 32'h0,        0, 0);
    add(1, 0, 32'h10, WORD,   32'h0,        32'hDEADBEEF, 0, 1);
    add(1, 0, 32'h13, BYTE,   32'h0,        32'hFFFFFFDE, 0, 1);
    add(1, 0, 32'h13, BYTE_U, 32'h0,        32'h000000DE, 0, 1);
    add(1, 0, 32'h10, HALF,   32'h0,        32'hFFFFBEEF, 0, 1);
    add(1, 0, 32'h12, HALF_U, 32'h0,        32'h0000DEAD, 0, 1);
    add(0, 1, 32'h11, BYTE,   32'h00000055, 32'h0,        0, 0);
    add(1, 0, 32'h10, WORD,   32'h0,        32'hDEAD55EF, 0, 1);
    add(0, 1, 32'h14, WORD,   32'h11223344, 32'h0,        0, 0);
    add(0, 1, 32'h16, HALF,   32'h0000CAFE, 32'h0,        0, 0);
    add(0, 1, 32'h17, BYTE,   32'hABCDEF99, 32'h0,        0, 0);
    add(1, 0, 32'h14, WORD,   32'h0,        32'h99FE3344, 0, 1);
    add(1, 0, 32'h16, HALF,   32'h0,        32'hFFFF99FE, 0, 1);
    add(1, 0, 32'h16, HALF_U, 32'h0,        32'h000099FE, 0, 1);
    add(1, 0, 32'h14, BYTE,   32'h0,        32'h00000044, 0, 1);
    add(1, 0, 32'h17, BYTE,   32'h0,        32'hFFFFFF99, 0, 1);
    add(1, 0, 32'h15, BYTE_U, 32'h0,        32'h00000033, 0, 1);
    add(0, 1, 32'h00, WORD,   32'h5A5A5A5A, 32'h0,        0, 0);
    add(0, 1, 32'(4*(DEPTH-1)), WORD, 32'h600DCAFE, 32'h0, 0, 0);
    add(1, 0, 32'(4*(DEPTH-1)), WORD, 32'h0, 32'h600DCAFE, 0, 1);
    add(1, 0, 32'h12, WORD,   32'h0,        32'h0,        1, 1);
    add(0, 1, 32'h11, HALF,   32'h00007777, 32'h0,        1, 1);
    add(1, 0, 32'(4*DEPTH), WORD, 32'h0,    32'h0,        1, 1);
    add(0, 1, 32'(4*DEPTH), WORD, 32'hBAD0BAD0, 32'h0,    1, 1);
    add(0, 1, 32'h10, BYTE_U, 32'h12345678, 32'h0,        1, 1);
    add(1, 0, 32'h10, 3'd3,   32'h0,        32'h0,        1, 1);
    add(1, 1, 32'h10, WORD,   32'h0,        32'h0,        1, 1);
    add(1, 0, 32'h13, HALF,   32'h0,        32'h0,        1, 1);
    add(1, 0, 32'hFFFFFFFC, WORD, 32'h0,    32'h0,        1, 1);
    add(1, 0, 32'h10, WORD,   32'h0,        32'hDEAD55EF, 0, 1);
    add(1, 0, 32'h00, WORD,   32'h0,        32'h5A5A5A5A, 0, 1);

    // Reset state, with a request pending on the bus.
    rst = 1'b1;
    bus.dbus_re = 1'b1; bus.dbus_we = 1'b0; bus.addr = 32'h0; bus.size = WORD;
    bus.wdata = 32'h0; bus.cycle_end = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", 32'(bus.stall), 32'h0);
    chk("rst_fault", 32'(bus.fault), 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    bus.dbus_re = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i], (i % 2) == 0, $sformatf("vec%0d", i));

    // Held write across DONE: exactly one commit, no stall, then cycle_end.
    v.re = 0; v.we = 1; v.addr = 32'h20; v.size = WORD; v.wdata = 32'h01020304;
    e.rdata = 32'h0; e.fault = 0; e.chk_rdata = 0;
    sb_q.push_back(e);
    drive(v);
    finish_txn("held_sw");
    bus.wdata = 32'h0BADF00D;
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      #1;
      if (bus.stall) bad = 1'b1;
    end
    chk("held_stall_low", 32'(bad), 32'h0);
    chk("held_fault", 32'(bus.fault), 32'h0);
    e.rdata = 32'h01020304; e.fault = 0; e.chk_rdata = 1;
    sb_q.push_back(e);
    bus.cycle_end = 1'b1; bus.dbus_we = 1'b0; bus.dbus_re = 1'b1; bus.wdata = 32'h0;
    @(negedge clk);
    bus.cycle_end = 1'b0;
    finish_txn("held_next_lw");
    bus.dbus_re = 1'b0;
    @(negedge clk);

    // Reset in the last BUSY cycle: stall drops at once, commit is dropped.
    bus.dbus_we = 1'b1; bus.addr = 32'h10; bus.size = WORD; bus.wdata = 32'hFFFFFFFF;
    #1;
    chk("mid_req_stall", 32'(bus.stall), 32'h1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_stall", 32'(bus.stall), 32'h0);
    chk("mid_rst_rdata", bus.rdata, 32'h0);
    chk("mid_rst_fault", 32'(bus.fault), 32'h0);
    @(negedge clk);
    #1;
    chk("mid_rst_hold_stall", 32'(bus.stall), 32'h0);
    bus.dbus_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    v.re = 1; v.we = 0; v.addr = 32'h10; v.size = WORD; v.wdata = 32'h0;
    v.exp_rdata = 32'hDEAD55EF; v.exp_fault = 0; v.chk_rdata = 1;
    run_vec(v, 1'b1, "post_rst_lw");

    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dbus_responder.md
DBUS_RESPONDER -- requirements
Module: dbus_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words in the internal data array.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, extra stall cycles per transaction; legal range 0..15.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port dbus_re  input  1  read request from the control unit.
REQ-006 SHALL have port dbus_we  input  1  write request from the control unit.
REQ-007 SHALL have port addr  input  32  byte address (ALU result).
REQ-008 SHALL have port size  input  3  access size, RISC-V f3 encoding.
REQ-009 SHALL have port wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port cycle_end  input  1  core strobe (write-back stage) closing the current transaction.
REQ-011 SHALL have port rdata  output  32  load data, extended per size.
REQ-012 SHALL have port stall  output  1  freezes the control-unit state machine while high.
REQ-013 SHALL have port fault  output  1  the completed transaction was illegal.

Function
REQ-014 SHALL implement states IDLE, BUSY and DONE.
REQ-015 SHALL accept a request in IDLE when dbus_re or dbus_we is high, latching addr, size, wdata and direction.
REQ-016 SHALL drive stall combinationally high during the request cycle in IDLE and during every BUSY cycle; low otherwise.
REQ-017 SHALL stay in BUSY for exactly WAIT_CYCLES cycles, then enter DONE; WAIT_CYCLES=0 goes IDLE->DONE directly.
REQ-018 SHALL commit a legal write exactly once, on the edge entering DONE, updating only the byte lanes selected by size and addr[1:0].
REQ-019 SHALL register rdata on the edge entering DONE: sizes 0/1 sign-extend, 4/5 zero-extend, 2 full word; rdata holds in DONE.
REQ-020 SHALL leave DONE for IDLE when cycle_end is high, or when dbus_re and dbus_we are both low; no new request is accepted in DONE.
REQ-021 SHALL flag a transaction illegal when: dbus_re and dbus_we are both high; size is 3, 6 or 7; a write uses size 4 or 5; a halfword has addr[0]=1; a word has addr[1:0]!=0; or addr[31:2] >= DEPTH_WORDS.
REQ-022 SHALL complete an illegal transaction with the same latency as a legal one, with no array write, rdata=0, and fault=1 throughout DONE.
REQ-023 SHALL hold fault at 0 outside DONE.
REQ-024 SHALL give total stalled cycles per transaction = WAIT_CYCLES+1.

Reset
REQ-025 SHALL, while rst is high, force state IDLE, stall=0, rdata=0 and fault=0, regardless of the current state.
REQ-026 SHALL drop any write whose commit edge coincides with asserted rst.
REQ-027 SHALL NOT clear the data array on reset.

Structure
REQ-028 SHALL place the dbus_size_t enum (BYTE=0, HALF=1, WORD=2, BYTE_U=4, HALF_U=5) and the responder state enum in package Types.
REQ-029 SHALL contain one combinational sub-module, dbus_lane_align, for store byte-enable/data merge and load extract/extend.

Verification
REQ-030 SHALL test a word store then load: WAIT_CYCLES=2; SW 0xDEADBEEF at 0x10 -> stall high 3 cycles, then LW 0x10 returns rdata=0xDEADBEEF, fault=0.
REQ-031 SHALL test a byte load with sign extension: after the REQ-030 store, LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF.
REQ-032 SHALL test a partial store: SB 0x55 at 0x11 over 0xDEADBEEF -> LW 0x10 returns 0xDEAD55EF.
REQ-033 SHALL test faults: LW 0x12, SH 0x11, and LW at 4*DEPTH_WORDS -> fault=1 in DONE, rdata=0, array unchanged.
REQ-034 SHALL test held requests: dbus_we held high across DONE with cycle_end=0 -> exactly one write and stall stays low; cycle_end pulse -> IDLE, next request accepted.
REQ-035 SHALL test reset mid-operation: rst asserted in BUSY -> stall=0 immediately, state IDLE, the target word keeps its old value.
